lfsr_fib_check: RTL and testbench

LFSR_FIB_CHECK -- requirements
Module: lfsr_fib_check

---
 rtl/lfsr_fib_check.sv | 173 +++++++++++++++++
 tb/tb_lfsr_fib_check.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_fib_check.sv
// PRBS checker for a Fibonacci-LFSR stream: hunts, verifies, then locks and
// flywheels on its own prediction, counting bit errors and checked bits while locked.
module lfsr_fib_check #(
  parameter int              LN         = 8,
  parameter logic [LN-1:0]   TAPS       = 8'h2d,
  parameter int              LOCK_COUNT = 16,
  parameter int              WINDOW     = 64,
  parameter int              ERR_THRESH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ce,
  input  logic        i_bit,
  input  logic        i_clear,
  output logic        o_locked,
  output logic        o_err,
  output logic [31:0] o_err_count,
  output logic [31:0] o_bit_count
);

  localparam int FW = $clog2(LN + 1);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Next-bit prediction from the history taps.
  function automatic logic predict(input logic [LN-1:0] hist);
    return ^(hist & TAPS);
  endfunction

  logic [1:0]    rst_sync_r;
  logic [1:0]    state_r, state_s;
  logic [LN-1:0] rreg_r, rreg_s;
  logic [FW-1:0] fill_r, fill_s;
  logic [RW-1:0] run_r, run_s;
  logic [BW-1:0] wbits_r, wbits_s;
  logic [EW-1:0] werrs_r, werrs_s;
  logic [31:0]   err_count_s, bit_count_s;
  logic          accept_s, pred_s, mism_s, err_s, inc_bits_s, inc_errs_s;

  // Reset release synchronizer; input bits are ignored until it has settled.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign accept_s = i_ce & rst_sync_r[1];
  assign pred_s   = predict(rreg_r);
  assign mism_s   = i_bit ^ pred_s;

  // State machine and history next-state.
  always_comb begin
    state_s    = state_r;
    rreg_s     = rreg_r;
    fill_s     = fill_r;
    run_s      = run_r;
    wbits_s    = wbits_r;
    werrs_s    = werrs_r;
    err_s      = 1'b0;
    inc_bits_s = 1'b0;
    inc_errs_s = 1'b0;
    if (accept_s) begin
      case (state_r)
        HUNT: begin
          rreg_s = {i_bit, rreg_r[LN-1:1]};
          if (fill_r == FW'(LN - 1)) begin
            state_s = VERIFY;
            fill_s  = '0;
            run_s   = '0;
          end else begin
            fill_s = fill_r + FW'(1);
          end
        end
        VERIFY: begin
          rreg_s = {i_bit, rreg_r[LN-1:1]};
          if (!mism_s && (rreg_r != '0)) begin
            if (run_r == RW'(LOCK_COUNT - 1)) begin
              state_s = LOCKED;
              run_s   = '0;
              wbits_s = '0;
              werrs_s = '0;
            end else begin
              run_s = run_r + RW'(1);
            end
          end else begin
            run_s = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction, not the received bit, feeds the history.
          rreg_s     = {pred_s, rreg_r[LN-1:1]};
          inc_bits_s = 1'b1;
          inc_errs_s = mism_s;
          err_s      = mism_s;
          if (mism_s && (werrs_r == EW'(ERR_THRESH - 1))) begin
            state_s = HUNT;
            fill_s  = '0;
            run_s   = '0;
            wbits_s = '0;
            werrs_s = '0;
          end else if (wbits_r == BW'(WINDOW - 1)) begin
            wbits_s = '0;
            werrs_s = '0;
          end else begin
            wbits_s = wbits_r + BW'(1);
            werrs_s = werrs_r + EW'(mism_s);
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Saturating output counters; a clear overrides a coincident increment.
  always_comb begin
    err_count_s = o_err_count;
    bit_count_s = o_bit_count;
    if (i_clear) begin
      err_count_s = 32'd0;
      bit_count_s = 32'd0;
    end else begin
      if (inc_errs_s && (o_err_count != 32'hFFFF_FFFF)) begin
        err_count_s = o_err_count + 32'd1;
      end else begin
        err_count_s = o_err_count;
      end
      if (inc_bits_s && (o_bit_count != 32'hFFFF_FFFF)) begin
        bit_count_s = o_bit_count + 32'd1;
      end else begin
        bit_count_s = o_bit_count;
      end
    end
  end

  // State, history and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= HUNT;
      rreg_r      <= '0;
      fill_r      <= '0;
      run_r       <= '0;
      wbits_r     <= '0;
      werrs_r     <= '0;
      o_locked    <= 1'b0;
      o_err       <= 1'b0;
      o_err_count <= 32'd0;
      o_bit_count <= 32'd0;
    end else begin
      state_r     <= state_s;
      rreg_r      <= rreg_s;
      fill_r      <= fill_s;
      run_r       <= run_s;
      wbits_r     <= wbits_s;
      werrs_r     <= werrs_s;
      o_locked    <= (state_s == LOCKED);
      o_err       <= err_s;
      o_err_count <= err_count_s;
      o_bit_count <= bit_count_s;
    end
  end

endmodule

// File: tb/tb_lfsr_fib_check.sv
// Directed and randomized bench for lfsr_fib_check with a queue-based
// reference model of the hunt/verify/lock behaviour.
module tb_lfsr_fib_check;

  localparam int         LN         = 8;
  localparam logic [7:0] TAPS       = 8'h2d;
  localparam logic [7:0] FILL       = 8'h01;
  localparam int         LOCK_COUNT = 16;
  localparam int         WINDOW     = 64;
  localparam int         ERR_THRESH = 8;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_ce = 1'b0;
  logic        i_bit = 1'b0;
  logic        i_clear = 1'b0;
  logic        o_locked, o_err;
  logic [31:0] o_err_count, o_bit_count;

  lfsr_fib_check #(
    .LN(LN), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW), .ERR_THRESH(ERR_THRESH)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_bit(i_bit), .i_clear(i_clear),
    .o_locked(o_locked), .o_err(o_err), .o_err_count(o_err_count), .o_bit_count(o_bit_count)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // transmitter sequence, generated on demand
  bit tx_q[$];
  int tx_n;

  function automatic bit tx_bit(input int n);
    bit nb;
    while (tx_q.size() <= n) begin
      nb = 1'b0;
      for (int k = 0; k < LN; k++) if (TAPS[k]) nb ^= tx_q[tx_q.size() - LN + k];
      tx_q.push_back(nb);
    end
    return tx_q[n];
  endfunction

  // reference model: hist[0] oldest, hist[LN-1] newest
  bit          hist[$];
  int          m_mode;   // 0 hunt, 1 verify, 2 locked
  int          m_fill, m_run, m_wbits, m_werrs;
  logic        exp_locked, exp_err;
  logic [31:0] exp_errc, exp_bitc;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < LN; k++) hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_run = 0; m_wbits = 0; m_werrs = 0;
    exp_locked = 1'b0; exp_err = 1'b0; exp_errc = 32'd0; exp_bitc = 32'd0;
  endtask

  task automatic model_step(input bit ce, input bit b, input bit clr);
    bit p, mis, nz;
    exp_err = 1'b0;
    if (ce) begin
      p = 1'b0; nz = 1'b0;
      for (int k = 0; k < LN; k++) begin
        if (TAPS[k]) p ^= hist[k];
        nz |= hist[k];
      end
      mis = (b != p);
      if (m_mode == 0) begin
        hist.push_back(b);
        m_fill++;
        if (m_fill == LN) begin m_mode = 1; m_fill = 0; m_run = 0; end
      end else if (m_mode == 1) begin
        hist.push_back(b);
        m_run = (!mis && nz) ? m_run + 1 : 0;
        if (m_run == LOCK_COUNT) begin m_mode = 2; m_run = 0; m_wbits = 0; m_werrs = 0; end
      end else begin
        hist.push_back(p);
        if (exp_bitc != 32'hFFFF_FFFF) exp_bitc++;
        if (mis) begin
          exp_err = 1'b1;
          if (exp_errc != 32'hFFFF_FFFF) exp_errc++;
          m_werrs++;
        end
        m_wbits++;
        if (m_werrs == ERR_THRESH) begin
          m_mode = 0; m_fill = 0; m_run = 0; m_wbits = 0; m_werrs = 0;
        end else if (m_wbits == WINDOW) begin
          m_wbits = 0; m_werrs = 0;
        end
      end
      void'(hist.pop_front());
    end
    if (clr) begin exp_errc = 32'd0; exp_bitc = 32'd0; end
    exp_locked = (m_mode == 2);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit ce, input bit b, input bit clr);
    i_ce = ce; i_bit = b; i_clear = clr;
    @(posedge i_clk);
    #1;
    model_step(ce, b, clr);
    chk("locked", {31'd0, o_locked}, {31'd0, exp_locked});
    chk("err", {31'd0, o_err}, {31'd0, exp_err});
    chk("err_count", o_err_count, exp_errc);
    chk("bit_count", o_bit_count, exp_bitc);
    i_ce = 1'b0; i_clear = 1'b0;
  endtask

  // send the next transmitter bit, optionally inverted
  task automatic send(input bit flip);
    step(1'b1, tx_bit(tx_n) ^ flip, 1'b0);
    tx_n++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_locked"}, {31'd0, o_locked}, 32'd0);
    chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
    chk({tag, "_errc"}, o_err_count, 32'd0);
    chk({tag, "_bitc"}, o_bit_count, 32'd0);
  endtask

  task automatic release_reset();
    i_reset_n = 1'b1;
    repeat (3) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    int acc;
    for (int k = 0; k < LN; k++) tx_q.push_back(FILL[k]);
    tx_n = 0;
    model_reset();

    // reset state, no clock needed
    #1;
    chk_reset_outputs("rst");
    repeat (2) @(posedge i_clk);
    #1;
    release_reset();

    // clean PRBS, lock after bit 24
    for (int n = 1; n <= 24; n++) begin
      send(1'b0);
      if (n == 23) chk("lock_bit23", {31'd0, o_locked}, 32'd0);
      if (n == 24) chk("lock_bit24", {31'd0, o_locked}, 32'd1);
    end
    for (int n = 0; n < 40; n++) send(1'b0);
    chk("bitc_40", o_bit_count, 32'd40);
    chk("errc_clean", o_err_count, 32'd0);

    // single error while locked
    send(1'b1);
    chk("single_err_pulse", {31'd0, o_err}, 32'd1);
    chk("single_errc", o_err_count, 32'd1);
    for (int n = 0; n < 10; n++) send(1'b0);
    chk("single_no_prop", o_err_count, 32'd1);

    // clear, finish the current window, then 8 flips force loss of lock
    step(1'b0, 1'b0, 1'b1);
    chk("clear_errc", o_err_count, 32'd0);
    for (int n = 0; n < 13; n++) send(1'b0);
    for (int f = 1; f <= 8; f++) begin
      send(1'b1);
      if (f == 7) chk("still_locked_7", {31'd0, o_locked}, 32'd1);
      if (f == 8) begin
        chk("unlock_8", {31'd0, o_locked}, 32'd0);
        chk("errc_8", o_err_count, 32'd8);
      end
      if (f < 8) begin send(1'b0); send(1'b0); end
    end
    for (int n = 1; n <= 24; n++) begin
      send(1'b0);
      if (n == 23) chk("relock_23", {31'd0, o_locked}, 32'd0);
      if (n == 24) chk("relock_24", {31'd0, o_locked}, 32'd1);
    end

    // clear coincident with a locked mismatch
    step(1'b1, tx_bit(tx_n) ^ 1'b1, 1'b1);
    tx_n++;
    chk("clr_err_pulse", {31'd0, o_err}, 32'd1);
    chk("clr_errc", o_err_count, 32'd0);

    // random errors, gaps and clears against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      else begin
        step(1'b1, tx_bit(tx_n) ^ ($urandom_range(0, 11) == 0), ($urandom_range(0, 99) == 0));
        tx_n++;
      end
    end

    // reset, restart transmitter, lock with random 50% ce gaps
    i_reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst2");
    model_reset();
    @(posedge i_clk);
    #1;
    release_reset();
    tx_n = 0;
    acc = 0;
    while (acc < 40) begin
      if ($urandom_range(0, 1) == 0) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      else begin
        send(1'b0);
        acc++;
        if (acc == 23) chk("gap_lock_23", {31'd0, o_locked}, 32'd0);
        if (acc == 24) chk("gap_lock_24", {31'd0, o_locked}, 32'd1);
      end
    end
    chk("gap_bitc", o_bit_count, 32'd16);

    // reset mid-lock takes effect without a clock edge
    #2;
    i_reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    model_reset();
    @(posedge i_clk);
    #1;
    release_reset();

    // all-zero input never locks
    for (int n = 0; n < 1000; n++) step(1'b1, 1'b0, 1'b0);
    chk("zero_locked", {31'd0, o_locked}, 32'd0);
    chk("zero_errc", o_err_count, 32'd0);
    chk("zero_bitc", o_bit_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
